stream_sink: RTL
================

# stream_sink

Terminal consumer for the dataflow operator chain. It accepts `R_IN`/`D_IN` words emitted by upstream operators and counts them against an expected total. Accepted words are buffered in an internal FIFO, which a host-side reader drains through a registered read port. `DONE` asserts when the expected number of words has arrived. The upstream protocol has no back-pressure, so loss on a full FIFO is flagged, never stalled.

## Interface
- `N`, default 16: data width; matches operator `D_OUT` width.
- `AW`, default 4: FIFO address width; depth = 2^AW words.
- `CW`, default 16: width of the expected-count and received-count fields.

- `CLK`, in, 1: clock; all logic on the rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `EN`, in, 1: gates input acceptance only; reads are not gated.
- `START`, in, 1: one-cycle pulse; begins a new collection run.
- `EXPECT`, in, CW: number of words expected; sampled when `START`=1.
- `R_IN`, in, 1: upstream word-valid.
- `D_IN`, in, N: upstream data.
- `RD_EN`, in, 1: host read request.
- `RD_VALID`, out, 1: `RD_DATA` holds a newly popped word this cycle.
- `RD_DATA`, out, N: popped word; holds its last value otherwise.
- `EMPTY`, out, 1: FIFO holds 0 words.
- `FULL`, out, 1: FIFO holds 2^AW words.
- `LEVEL`, out, AW+1: current FIFO occupancy.
- `COUNT`, out, CW: words observed in the current run, including dropped words.
- `DONE`, out, 1: `COUNT` has reached the latched `EXPECT`.
- `OVERFLOW`, out, 1: sticky; at least one word was dropped in the current run.

## Operation
- FSM states: IDLE, RECV, FIN.
- IDLE
  - `R_IN` is ignored.
  - `START` latches `EXPECT` into `exp_q`, flushes the FIFO and clears `COUNT`, `DONE` and `OVERFLOW`.
  - Next state is RECV, or FIN if `EXPECT`=0.
- RECV
  - A word is observed when `EN`=1 and `R_IN`=1; `COUNT` increments by 1 on each observed word.
  - The word is written to the FIFO if not FULL, or if a pop occurs in the same cycle (pop-before-push; LEVEL unchanged).
  - Otherwise the word is dropped and `OVERFLOW` is set.
  - When the observed word makes `COUNT` equal `exp_q`: move to FIN and set `DONE`=1 on that same edge.
- FIN
  - `R_IN` is ignored; nothing is counted or written.
  - `DONE` stays at 1.
  - The FIFO remains readable.
- `START` in any state, including RECV and FIN, restarts the run exactly as described for IDLE. The FIFO flush discards unread words.
- Read port
  - `RD_EN`=1 with FIFO not EMPTY pops one word.
  - `RD_EN`=1 while EMPTY is ignored; no underflow, no pointer movement.
- Pointers are AW+1 bits and wrap modulo 2^(AW+1).
  - FULL is asserted when the MSBs differ and the lower AW bits are equal.
  - EMPTY is asserted when the pointers are equal.
- `COUNT` saturates at 2^CW−1 and never wraps.
- `EXPECT` and `START` are ignored while `RST`=1.

## Timing
- Reset values
  - State = IDLE; pointers = 0.
  - `RD_VALID`=0, `RD_DATA`=0, `EMPTY`=1, `FULL`=0, `LEVEL`=0.
  - `COUNT`=0, `DONE`=0, `OVERFLOW`=0, `exp_q`=0.
- `RST` mid-run discards all FIFO contents and run state within one edge.
- Write latency: a word accepted at edge k is reflected in `EMPTY`, `LEVEL` and `COUNT` after edge k. It is poppable by `RD_EN` in the cycle following edge k.
- Read latency is 1 cycle: `RD_EN` at edge k produces `RD_DATA` and `RD_VALID`=1 after edge k. `RD_VALID` is high for exactly one cycle per pop.
- Back-to-back `RD_EN` yields one word per cycle, in FIFO order.
- `START` at edge k: flush and clear take effect after edge k. `R_IN` is counted starting from edge k+1.
  - If `R_IN`=1 at the same edge as `START`, that word is ignored.
- A read and `START` at the same edge: `START` wins; `RD_VALID`=0.
- All outputs are registered or derived from registered pointers; no combinational path from inputs to outputs.

## Test plan
- **Basic run.** Reset, then `START` with `EXPECT`=3. Drive `R_IN`=1 with `EN`=1 for 3 cycles, data 0x0001, 0x0002, 0x0003.
  - `COUNT`=3, `DONE`=1 on the third edge, `LEVEL`=3.
  - Three `RD_EN` pops give `RD_DATA` 1, 2, 3 with `RD_VALID` pulses, then `EMPTY`=1.
- **EN gating.** `START` with `EXPECT`=4, AW=4. Drive 4 words with `EN`=0 interleaved.
  - Words with `EN`=0 are not counted.
  - A 5th word arriving in FIN is ignored: `COUNT`=4, `LEVEL`=4.
- **Overflow.** `START` with `EXPECT`=20, AW=4. Drive 18 words, no reads.
  - `FULL` after 16 words, `OVERFLOW`=1, `COUNT`=18, `LEVEL`=16.
  - Words 0–15 are read back intact.
- **Full with simultaneous pop.** Fill to 16 words, then assert `R_IN` and `RD_EN` in the same cycle.
  - `LEVEL` stays 16, `OVERFLOW` stays 0.
  - The new word is read back last.
- **Zero expect and restart.** `START` with `EXPECT`=0 gives `DONE`=1 after 1 edge.
  - `START` with `EXPECT`=5 mid-run, with 3 words buffered: `LEVEL`=0, `COUNT`=0, `DONE`=0.
- **Reset and underflow.** `RST` mid-run gives all reset values.
  - `RD_EN` while EMPTY gives `RD_VALID`=0 and `RD_DATA` unchanged.

Source files
------------

// File: rtl/stream_sink_if.sv
// Upstream word stream plus host read port of the stream sink.
// The master side is the upstream operator and host reader; the slave side is the sink.
interface stream_sink_if #(
  parameter int N = 16
);
  logic         R_IN;
  logic [N-1:0] D_IN;
  logic         RD_EN;
  logic         RD_VALID;
  logic [N-1:0] RD_DATA;

  modport master (output R_IN, D_IN, RD_EN, input  RD_VALID, RD_DATA);
  modport slave  (input  R_IN, D_IN, RD_EN, output RD_VALID, RD_DATA);
endinterface

// File: rtl/stream_sink.sv
// Terminal consumer of the operator chain: counts incoming words against an expected total,
// buffers them in a FIFO drained through a registered read port, and flags loss on a full FIFO.
module stream_sink #(
  parameter int N  = 16,
  parameter int AW = 4,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          START,
  input  logic [CW-1:0] EXPECT,
  stream_sink_if.slave  bus,
  output logic          EMPTY,
  output logic          FULL,
  output logic [AW:0]   LEVEL,
  output logic [CW-1:0] COUNT,
  output logic          DONE,
  output logic          OVERFLOW
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, RECV, FIN} state_t;

  state_t        state;
  logic [N-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [CW-1:0] exp_q;
  logic [CW-1:0] count_inc;
  logic          pop, observed, push;

  // Status comes straight from the registered pointers, so no input reaches an output combinationally.
  assign EMPTY = (wr_ptr == rd_ptr);
  assign FULL  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign LEVEL = wr_ptr - rd_ptr;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    pop       = 1'b0;
    observed  = 1'b0;
    push      = 1'b0;
    count_inc = COUNT;
    if (!START) begin
      pop      = bus.RD_EN && !EMPTY;
      observed = (state == RECV) && EN && bus.R_IN;
      push     = observed && (!FULL || pop);
    end
    if (COUNT != '1) count_inc = COUNT + 1'b1;
  end

  // NOTE: storage is deliberately not reset; pointers define validity, and a resettable array costs a mux per bit.
  always_ff @(posedge CLK) begin
    if (push && !RST) mem[wr_ptr[AW-1:0]] <= bus.D_IN;
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (RST) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      exp_q        <= '0;
      COUNT        <= '0;
      DONE         <= 1'b0;
      OVERFLOW     <= 1'b0;
      bus.RD_VALID <= 1'b0;
      bus.RD_DATA  <= '0;
    end else begin
      bus.RD_VALID <= pop;
      if (pop) bus.RD_DATA <= mem[rd_ptr[AW-1:0]];

      if (START) begin
        // A restart flushes unread words and wins over any read or word in the same cycle.
        exp_q    <= EXPECT;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        COUNT    <= '0;
        OVERFLOW <= 1'b0;
        DONE     <= (EXPECT == '0);
        state    <= (EXPECT == '0) ? FIN : RECV;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (observed) begin
          COUNT <= count_inc;
          if (!push) OVERFLOW <= 1'b1;
          if (count_inc == exp_q) begin
            state <= FIN;
            DONE  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
